cdb_issue_scheduler: RTL and testbench

CDB_ISSUE_SCHEDULER -- requirements
Module: cdb_issue_scheduler

---
 rtl/cdb_issue_scheduler.sv | 84 ++++++++
 tb/tb_cdb_issue_scheduler.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/cdb_issue_scheduler.sv
// Issue scheduler in front of the CDB controller: grants int, mult, div and
// load-buffer requests so that at most one source drives the CDB per cycle.
// A reservation vector tracks future CDB slots claimed by multi-cycle units.
module cdb_issue_scheduler #(
  parameter int unsigned MULT_LAT = 4,
  parameter int unsigned DIV_LAT  = 7,
  parameter int unsigned STALL_W  = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req_int,
  input  logic               req_mult,
  input  logic               req_div,
  input  logic               req_ls_buf,
  output logic               issue_int,
  output logic               issue_mult,
  output logic               issue_div,
  output logic               issue_ls_buf,
  output logic [2:0]         slots_reserved,
  output logic [STALL_W-1:0] stall_count
);

  logic [DIV_LAT-1:0] occ_q, occ_d;
  logic               rr_q, rr_d;
  logic [2:0]         slots_q, slots_d;
  logic [STALL_W-1:0] stall_q, stall_d;

  logic grant_int, grant_mult, grant_div, grant_ls;
  logic slot0_free, contested, any_stall;

  // Same-cycle grants; reset masks every grant regardless of requests.
  always_comb begin
    slot0_free = ~occ_q[0] & ~reset;
    grant_div  = req_div & ~reset;
    grant_mult = req_mult & ~occ_q[MULT_LAT] & ~reset;
    contested  = req_int & req_ls_buf & slot0_free;
    grant_int  = slot0_free & req_int    & (~req_ls_buf | ~rr_q);
    grant_ls   = slot0_free & req_ls_buf & (~req_int    |  rr_q);
  end

  // Next reservation vector, popcount, round-robin pointer and stall counter.
  always_comb begin
    occ_d = {grant_div, occ_q[DIV_LAT-1:1]};
    if (grant_mult) occ_d[MULT_LAT-1] = 1'b1;

    slots_d = '0;
    for (int unsigned k = 0; k < DIV_LAT; k++) begin
      slots_d = slots_d + 3'(occ_d[k]);
    end

    rr_d = rr_q;
    if (contested) rr_d = ~rr_q;

    any_stall = (req_int    & ~grant_int)  |
                (req_mult   & ~grant_mult) |
                (req_div    & ~grant_div)  |
                (req_ls_buf & ~grant_ls);
    stall_d = stall_q;
    if (any_stall && (stall_q != '1)) stall_d = stall_q + STALL_W'(1);
  end

  // State registers; asynchronous reset drops all reservations at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      occ_q   <= '0;
      rr_q    <= 1'b0;
      slots_q <= '0;
      stall_q <= '0;
    end else begin
      occ_q   <= occ_d;
      rr_q    <= rr_d;
      slots_q <= slots_d;
      stall_q <= stall_d;
    end
  end

  assign issue_int      = grant_int;
  assign issue_mult     = grant_mult;
  assign issue_div      = grant_div;
  assign issue_ls_buf   = grant_ls;
  assign slots_reserved = slots_q;
  assign stall_count    = stall_q;

endmodule

// File: tb/tb_cdb_issue_scheduler.sv
// Self-checking bench for cdb_issue_scheduler: a directed cycle table plus a
// random request stream checked against an independent CDB occupancy model.
module tb_cdb_issue_scheduler;

  localparam int unsigned MULT_LAT = 4;
  localparam int unsigned DIV_LAT  = 7;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic req_int = 1'b0, req_mult = 1'b0, req_div = 1'b0, req_ls_buf = 1'b0;
  logic issue_int, issue_mult, issue_div, issue_ls_buf;
  logic [2:0]  slots_reserved;
  logic [15:0] stall_count;
  logic s_int, s_mult, s_div, s_ls;
  logic [2:0]  s_slots;
  logic [2:0]  s_stall;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  cdb_issue_scheduler #(.MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT), .STALL_W(16)) dut (
    .clk(clk), .reset(reset),
    .req_int(req_int), .req_mult(req_mult), .req_div(req_div), .req_ls_buf(req_ls_buf),
    .issue_int(issue_int), .issue_mult(issue_mult), .issue_div(issue_div),
    .issue_ls_buf(issue_ls_buf), .slots_reserved(slots_reserved), .stall_count(stall_count)
  );

  // Narrow stall counter instance, used to observe saturation.
  cdb_issue_scheduler #(.MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT), .STALL_W(3)) u_sat (
    .clk(clk), .reset(reset),
    .req_int(req_int), .req_mult(req_mult), .req_div(req_div), .req_ls_buf(req_ls_buf),
    .issue_int(s_int), .issue_mult(s_mult), .issue_div(s_div),
    .issue_ls_buf(s_ls), .slots_reserved(s_slots), .stall_count(s_stall)
  );

  // iss = {int, mult, div, ls}; slots/stall are the registered values seen
  // during the row's cycle.
  typedef struct {
    logic       rst, ri, rm, rd, rl;
    logic [3:0] iss;
    logic [2:0] slots;
    int         stall;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic rst, ri, rm, rd, rl,
                     input logic [3:0] iss, input int slots, input int stall);
    vec_t v;
    v.rst = rst; v.ri = ri; v.rm = rm; v.rd = rd; v.rl = rl;
    v.iss = iss; v.slots = 3'(slots); v.stall = stall;
    tbl.push_back(v);
  endtask

  task automatic check(input string name, input int row, input logic [15:0] got,
                       input logic [15:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s row %0d: got %0h expected %0h", name, row, got, exp);
    end
  endtask

  int cnt[DIV_LAT+1];
  int w_int, w_mult, w_div, w_ls, max_wait;
  int sel, occ_pop;
  int sat;

  initial begin
    //  rst ri rm rd rl   iss(i m d l) slots stall
    add(1, 1, 1, 1, 1, 4'b0000, 0, 0);   // 0 reset masks grants
    add(0, 1, 0, 0, 1, 4'b1000, 0, 0);   // 1 contested, rr=0 -> int
    add(0, 1, 0, 0, 1, 4'b0001, 0, 1);   // 2 -> ls
    add(0, 1, 0, 0, 1, 4'b1000, 0, 2);   // 3 -> int
    add(0, 1, 0, 0, 1, 4'b0001, 0, 3);   // 4 -> ls
    add(0, 0, 0, 0, 0, 4'b0000, 0, 4);   // 5 stall=4
    add(0, 0, 1, 0, 0, 4'b0100, 0, 4);   // 6 mult granted
    add(0, 0, 0, 0, 0, 4'b0000, 1, 4);   // 7
    add(0, 0, 0, 0, 0, 4'b0000, 1, 4);   // 8
    add(0, 0, 0, 0, 0, 4'b0000, 1, 4);   // 9
    add(0, 1, 0, 0, 0, 4'b0000, 1, 4);   // 10 slot0 taken by mult
    add(0, 1, 0, 0, 0, 4'b1000, 0, 5);   // 11 int granted
    add(0, 0, 0, 0, 0, 4'b0000, 0, 5);   // 12
    add(0, 0, 0, 1, 0, 4'b0010, 0, 5);   // 13 div granted
    add(0, 0, 0, 0, 0, 4'b0000, 1, 5);   // 14
    add(0, 0, 0, 0, 0, 4'b0000, 1, 5);   // 15
    add(0, 0, 1, 0, 0, 4'b0000, 1, 5);   // 16 mult blocked by div
    add(0, 0, 1, 0, 0, 4'b0100, 1, 6);   // 17 mult granted
    add(0, 0, 0, 0, 0, 4'b0000, 2, 6);   // 18
    add(0, 0, 0, 0, 0, 4'b0000, 2, 6);   // 19
    add(0, 1, 0, 0, 0, 4'b0000, 2, 6);   // 20 div on CDB
    add(0, 0, 0, 0, 1, 4'b0000, 1, 7);   // 21 mult on CDB
    add(0, 0, 0, 0, 1, 4'b0001, 0, 8);   // 22 ls uncontested
    add(0, 1, 1, 1, 0, 4'b1110, 0, 8);   // 23 three grants at once
    add(0, 0, 0, 0, 0, 4'b0000, 2, 8);   // 24
    add(0, 0, 0, 0, 0, 4'b0000, 2, 8);   // 25
    add(0, 1, 0, 0, 1, 4'b1000, 2, 8);   // 26 contested, rr=0 -> int
    add(0, 1, 0, 0, 1, 4'b0000, 2, 9);   // 27 slot0 taken, rr holds
    add(0, 1, 0, 0, 1, 4'b0001, 1, 10);  // 28 rr=1 -> ls
    add(0, 0, 0, 0, 0, 4'b0000, 1, 11);  // 29
    add(0, 1, 0, 0, 1, 4'b0000, 1, 11);  // 30 slot0 taken by div
    add(0, 1, 0, 0, 1, 4'b1000, 0, 12);  // 31 rr=0 -> int, rr becomes 1
    add(0, 0, 0, 1, 0, 4'b0010, 0, 13);  // 32 div granted
    add(0, 0, 0, 0, 0, 4'b0000, 1, 13);  // 33
    add(1, 1, 0, 0, 0, 4'b0000, 0, 0);   // 34 async reset mid-flight
    add(0, 1, 0, 0, 0, 4'b1000, 0, 0);   // 35 granted right after release
    add(0, 0, 0, 0, 0, 4'b0000, 0, 0);   // 36
    add(0, 1, 0, 0, 1, 4'b1000, 0, 0);   // 37 rr cleared by reset -> int
    add(0, 0, 0, 0, 0, 4'b0000, 0, 1);   // 38

    foreach (tbl[i]) begin
      @(posedge clk);
      #1;
      reset = tbl[i].rst; req_int = tbl[i].ri; req_mult = tbl[i].rm;
      req_div = tbl[i].rd; req_ls_buf = tbl[i].rl;
      #5;
      check("issue", i, 16'({issue_int, issue_mult, issue_div, issue_ls_buf}), 16'(tbl[i].iss));
      check("slots", i, 16'(slots_reserved), 16'(tbl[i].slots));
      check("stall", i, stall_count, 16'(tbl[i].stall));
      sat = (tbl[i].stall > 7) ? 7 : tbl[i].stall;
      check("stall_sat", i, 16'(s_stall), 16'(sat));
    end

    // Random stream: requests held until granted, CDB occupancy modelled
    // from the observed grants and their fixed latencies.
    @(posedge clk); #1;
    reset = 1'b1; req_int = 0; req_mult = 0; req_div = 0; req_ls_buf = 0;
    @(posedge clk); #1;
    reset = 1'b0;
    for (int k = 0; k <= DIV_LAT; k++) cnt[k] = 0;
    w_int = 0; w_mult = 0; w_div = 0; w_ls = 0; max_wait = 0;
    for (int c = 0; c < 2000; c++) begin
      @(posedge clk);
      #1;
      if (!(req_int && w_int > 0))    req_int    = ($urandom_range(0, 1) == 1);
      if (!(req_ls_buf && w_ls > 0))  req_ls_buf = ($urandom_range(0, 1) == 1);
      if (!(req_mult && w_mult > 0))  req_mult   = ($urandom_range(0, 7) == 0);
      if (!(req_div && w_div > 0))    req_div    = ($urandom_range(0, 15) == 0);
      #5;
      sel = cnt[0] + int'(issue_int) + int'(issue_ls_buf);
      check("cdb_onehot", c, 16'(sel > 1), 16'(0));
      occ_pop = 0;
      for (int k = 0; k < DIV_LAT; k++) if (cnt[k] > 0) occ_pop++;
      check("rand_slots", c, 16'(slots_reserved), 16'(occ_pop));
      check("rand_grant_wo_req", c,
            16'({issue_int & ~req_int, issue_mult & ~req_mult,
                 issue_div & ~req_div, issue_ls_buf & ~req_ls_buf}), 16'(0));
      w_int  = (req_int    && !issue_int)    ? w_int + 1  : 0;
      w_ls   = (req_ls_buf && !issue_ls_buf) ? w_ls + 1   : 0;
      w_mult = (req_mult   && !issue_mult)   ? w_mult + 1 : 0;
      w_div  = (req_div    && !issue_div)    ? w_div + 1  : 0;
      if (w_int > max_wait)  max_wait = w_int;
      if (w_ls > max_wait)   max_wait = w_ls;
      if (w_mult > max_wait) max_wait = w_mult;
      if (w_div > max_wait)  max_wait = w_div;
      for (int k = 0; k < DIV_LAT; k++) cnt[k] = cnt[k+1];
      cnt[DIV_LAT] = 0;
      if (issue_mult) cnt[MULT_LAT-1] = cnt[MULT_LAT-1] + 1;
      if (issue_div)  cnt[DIV_LAT-1]  = cnt[DIV_LAT-1] + 1;
    end
    check("max_wait", 0, 16'(max_wait > int'(DIV_LAT) + 2), 16'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
